// File: rtl/reg_status_table_pkg.sv
// Shared definitions for the register status (rename) table and its read ports.
package reg_status_table_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned ROB_W      = 3;
    localparam int unsigned BUSY_CNT_W = 6;

    typedef logic [ROB_W-1:0]      tag_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

    function automatic logic [BUSY_CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [BUSY_CNT_W-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cnt = cnt + BUSY_CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/reg_status_read_port.sv
// One registered lookup port of the status table: x0 reads as idle, valid pulses
// for one cycle per request.
module reg_status_read_port
    import reg_status_table_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = ROB_W
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                rdy_i,
    input  logic                                req_i,
    input  logic [REG_ADDR_W-1:0]               addr_i,
    input  logic [NUM_REGS-1:0]                 busy_i,
    input  logic [NUM_REGS-1:0][ROB_WIDTH-1:0]  tag_i,
    output logic                                valid_o,
    output logic                                busy_o,
    output logic [ROB_WIDTH-1:0]                tag_o
);

    logic                 valid_q, valid_d;
    logic                 busy_q,  busy_d;
    logic [ROB_WIDTH-1:0] tag_q,   tag_d;

    always_comb begin
        valid_d = req_i;
        busy_d  = busy_q;
        tag_d   = tag_q;
        if (req_i) begin
            if (addr_i == REG_ZERO) begin
                busy_d = 1'b0;
                tag_d  = '0;
            end else begin
                busy_d = busy_i[addr_i];
                tag_d  = tag_i[addr_i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            tag_q   <= '0;
        end else if (rdy_i) begin
            valid_q <= valid_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/reg_status_table.sv
// Register status table: per-register pending-writer busy bit and ROB tag.
// Optional busy_count output enabled by defining REG_STATUS_BUSY_CNT_EN.
module reg_status_table
    import reg_status_table_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = ROB_W,
    parameter int unsigned RS_WIDTH  = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    from_issue_valid,
    input  logic [REG_ADDR_W-1:0]   from_issue_rd,
    input  logic [ROB_WIDTH-1:0]    from_issue_tag,
    input  logic                    from_rs_rs1_flag,
    input  logic                    from_rs_rs2_flag,
    input  logic [REG_ADDR_W-1:0]   from_rs_rs1,
    input  logic [REG_ADDR_W-1:0]   from_rs_rs2,
    input  logic [RS_WIDTH-1:0]     from_rs_index,
    input  logic                    from_rob,
    input  logic [REG_ADDR_W-1:0]   from_rob_rd,
    input  logic [ROB_WIDTH-1:0]    from_rob_tag,
    input  logic                    from_rob_flush,
`ifdef REG_STATUS_BUSY_CNT_EN
    output logic [BUSY_CNT_W-1:0]   busy_count,
`endif
    output logic                    to_rs_rs1_flag,
    output logic                    to_rs_rs2_flag,
    output logic [RS_WIDTH-1:0]     to_rs_index,
    output logic                    to_rs_rs1_busy,
    output logic [ROB_WIDTH-1:0]    to_rs_rs1_tag,
    output logic                    to_rs_rs2_busy,
    output logic [ROB_WIDTH-1:0]    to_rs_rs2_tag
);

    logic [NUM_REGS-1:0]                busy_q, busy_d;
    logic [NUM_REGS-1:0][ROB_WIDTH-1:0] tag_q,  tag_d;
    logic [RS_WIDTH-1:0]                index_q, index_d;

    // Flush beats everything; otherwise commit clears only if it still owns the
    // entry, and a same-cycle issue overrides the commit.
    always_comb begin
        busy_d  = busy_q;
        tag_d   = tag_q;
        index_d = index_q;
        if (from_rs_rs1_flag || from_rs_rs2_flag) begin
            index_d = from_rs_index;
        end
        if (from_rob_flush) begin
            busy_d = '0;
        end else begin
            if (from_rob && (from_rob_rd != REG_ZERO)
                && (tag_q[from_rob_rd] == from_rob_tag)) begin
                busy_d[from_rob_rd] = 1'b0;
            end
            if (from_issue_valid && (from_issue_rd != REG_ZERO)) begin
                busy_d[from_issue_rd] = 1'b1;
                tag_d[from_issue_rd]  = from_issue_tag;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q  <= '0;
            tag_q   <= '0;
            index_q <= '0;
        end else if (rdy_in) begin
            busy_q  <= busy_d;
            tag_q   <= tag_d;
            index_q <= index_d;
        end
    end

    assign to_rs_index = index_q;

`ifdef REG_STATUS_BUSY_CNT_EN
    logic [BUSY_CNT_W-1:0] busy_cnt_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_cnt_q <= '0;
        end else if (rdy_in) begin
            busy_cnt_q <= popcount(busy_d);
        end
    end

    assign busy_count = busy_cnt_q;
`endif

    // Lookups see pre-edge table state, matching the register file's read.
    reg_status_read_port #(.ROB_WIDTH(ROB_WIDTH)) u_rs1_port (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .rdy_i   (rdy_in),
        .req_i   (from_rs_rs1_flag),
        .addr_i  (from_rs_rs1),
        .busy_i  (busy_q),
        .tag_i   (tag_q),
        .valid_o (to_rs_rs1_flag),
        .busy_o  (to_rs_rs1_busy),
        .tag_o   (to_rs_rs1_tag)
    );

    reg_status_read_port #(.ROB_WIDTH(ROB_WIDTH)) u_rs2_port (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .rdy_i   (rdy_in),
        .req_i   (from_rs_rs2_flag),
        .addr_i  (from_rs_rs2),
        .busy_i  (busy_q),
        .tag_i   (tag_q),
        .valid_o (to_rs_rs2_flag),
        .busy_o  (to_rs_rs2_busy),
        .tag_o   (to_rs_rs2_tag)
    );

endmodule

// File: tb/tb_reg_status_table.sv
// Scoreboard bench for reg_status_table: lookups push expected results, a
// negedge monitor pops and compares whenever a result flag is up.
module tb_reg_status_table;

    logic       clk_in;
    logic       rst_in;
    logic       rdy_in;
    logic       from_issue_valid;
    logic [4:0] from_issue_rd;
    logic [2:0] from_issue_tag;
    logic       from_rs_rs1_flag;
    logic       from_rs_rs2_flag;
    logic [4:0] from_rs_rs1;
    logic [4:0] from_rs_rs2;
    logic [1:0] from_rs_index;
    logic       from_rob;
    logic [4:0] from_rob_rd;
    logic [2:0] from_rob_tag;
    logic       from_rob_flush;
    logic       to_rs_rs1_flag;
    logic       to_rs_rs2_flag;
    logic [1:0] to_rs_index;
    logic       to_rs_rs1_busy;
    logic [2:0] to_rs_rs1_tag;
    logic       to_rs_rs2_busy;
    logic [2:0] to_rs_rs2_tag;
`ifdef REG_STATUS_BUSY_CNT_EN
    logic [5:0] busy_count;
`endif

    typedef struct {
        logic       busy;
        logic [2:0] tag;
        logic [1:0] idx;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   total = 0;
    int   bad   = 0;

    reg_status_table #(.ROB_WIDTH(3), .RS_WIDTH(2)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
        .from_issue_valid (from_issue_valid),
        .from_issue_rd    (from_issue_rd),
        .from_issue_tag   (from_issue_tag),
        .from_rs_rs1_flag (from_rs_rs1_flag),
        .from_rs_rs2_flag (from_rs_rs2_flag),
        .from_rs_rs1      (from_rs_rs1),
        .from_rs_rs2      (from_rs_rs2),
        .from_rs_index    (from_rs_index),
        .from_rob         (from_rob),
        .from_rob_rd      (from_rob_rd),
        .from_rob_tag     (from_rob_tag),
        .from_rob_flush   (from_rob_flush),
`ifdef REG_STATUS_BUSY_CNT_EN
        .busy_count       (busy_count),
`endif
        .to_rs_rs1_flag   (to_rs_rs1_flag),
        .to_rs_rs2_flag   (to_rs_rs2_flag),
        .to_rs_index      (to_rs_index),
        .to_rs_rs1_busy   (to_rs_rs1_busy),
        .to_rs_rs1_tag    (to_rs_rs1_tag),
        .to_rs_rs2_busy   (to_rs_rs2_busy),
        .to_rs_rs2_tag    (to_rs_rs2_tag)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        from_issue_valid = 1'b0; from_issue_rd = '0; from_issue_tag = '0;
        from_rs_rs1_flag = 1'b0; from_rs_rs2_flag = 1'b0;
        from_rs_rs1 = '0; from_rs_rs2 = '0; from_rs_index = '0;
        from_rob = 1'b0; from_rob_rd = '0; from_rob_tag = '0;
        from_rob_flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        idle();
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] tag);
        from_issue_valid = 1'b1; from_issue_rd = rd; from_issue_tag = tag;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [2:0] tag);
        from_rob = 1'b1; from_rob_rd = rd; from_rob_tag = tag;
    endtask

    task automatic look1(input logic [4:0] r, input logic [1:0] idx,
                         input logic b, input logic [2:0] t);
        exp_t e;
        from_rs_rs1_flag = 1'b1; from_rs_rs1 = r; from_rs_index = idx;
        e.busy = b; e.tag = t; e.idx = idx;
        q1.push_back(e);
    endtask

    task automatic look2(input logic [4:0] r, input logic [1:0] idx,
                         input logic b, input logic [2:0] t);
        exp_t e;
        from_rs_rs2_flag = 1'b1; from_rs_rs2 = r; from_rs_index = idx;
        e.busy = b; e.tag = t; e.idx = idx;
        q2.push_back(e);
    endtask

    // Monitor: each asserted result flag consumes one expectation.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (to_rs_rs1_flag) begin
                if (q1.size() == 0) begin
                    chk("rs1_unexpected_flag", 1, 0);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("rs1_busy", int'(to_rs_rs1_busy), int'(e.busy));
                    chk("rs1_tag",  int'(to_rs_rs1_tag),  int'(e.tag));
                    chk("rs1_index", int'(to_rs_index),   int'(e.idx));
                end
            end
            if (to_rs_rs2_flag) begin
                if (q2.size() == 0) begin
                    chk("rs2_unexpected_flag", 1, 0);
                end else begin
                    exp_t e;
                    e = q2.pop_front();
                    chk("rs2_busy", int'(to_rs_rs2_busy), int'(e.busy));
                    chk("rs2_tag",  int'(to_rs_rs2_tag),  int'(e.tag));
                    chk("rs2_index", int'(to_rs_index),   int'(e.idx));
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        idle();
        #12;
        chk("reset_rs1_flag", int'(to_rs_rs1_flag), 0);
        chk("reset_rs2_flag", int'(to_rs_rs2_flag), 0);
        chk("reset_index",    int'(to_rs_index),    0);
        chk("reset_rs1_busy", int'(to_rs_rs1_busy), 0);
        chk("reset_rs2_tag",  int'(to_rs_rs2_tag),  0);
        rst_in = 1'b0;
        tick();

        // Mid-run async reset with busy[5]=1 and a live result on the outputs
        issue(5'd5, 3'd6);
        tick();
        from_rs_rs1_flag = 1'b1; from_rs_rs1 = 5'd5; from_rs_index = 2'd1;
        tick();
        chk("pre_rst_rs1_flag", int'(to_rs_rs1_flag), 1);
        chk("pre_rst_rs1_busy", int'(to_rs_rs1_busy), 1);
        chk("pre_rst_rs1_tag",  int'(to_rs_rs1_tag),  6);
        #1 rst_in = 1'b1;
        #1;
        chk("async_rst_flag", int'(to_rs_rs1_flag), 0);
        chk("async_rst_busy", int'(to_rs_rs1_busy), 0);
        chk("async_rst_tag",  int'(to_rs_rs1_tag),  0);
        chk("async_rst_idx",  int'(to_rs_index),    0);
        #5 rst_in = 1'b0;
        look1(5'd5, 2'd1, 1'b0, 3'd0);
        tick();
        tick();

        // Issue then lookup
        issue(5'd7, 3'd3);
        tick();
        look1(5'd7, 2'd2, 1'b1, 3'd3);
        tick();

        // Younger writer keeps ownership against older commit
        issue(5'd7, 3'd5);
        tick();
        commit(5'd7, 3'd3);
        tick();
        look1(5'd7, 2'd3, 1'b1, 3'd5);
        tick();
        commit(5'd7, 3'd5);
        tick();
        look1(5'd7, 2'd3, 1'b0, 3'd5);
        tick();

        // Same-cycle commit + issue + lookup on rd 9
        issue(5'd9, 3'd1);
        tick();
        commit(5'd9, 3'd1);
        issue(5'd9, 3'd4);
        look2(5'd9, 2'd1, 1'b1, 3'd1);
        tick();
        look2(5'd9, 2'd1, 1'b1, 3'd4);
        tick();
        look1(5'd7, 2'd0, 1'b0, 3'd5);
        look2(5'd9, 2'd0, 1'b1, 3'd4);
        tick();
        commit(5'd9, 3'd4);
        tick();

        // x0 never becomes busy
        issue(5'd0, 3'd2);
        tick();
        look1(5'd0, 2'd2, 1'b0, 3'd0);
        tick();

        // Flush with registers 3, 8, 31 busy
        issue(5'd3, 3'd1);
        tick();
        issue(5'd8, 3'd2);
        tick();
        issue(5'd31, 3'd7);
        tick();
`ifdef REG_STATUS_BUSY_CNT_EN
        chk("busy_count_pre_flush", int'(busy_count), 3);
`endif
        look1(5'd31, 2'd3, 1'b1, 3'd7);
        look2(5'd8,  2'd3, 1'b1, 3'd2);
        tick();
        from_rob_flush = 1'b1;
        issue(5'd12, 3'd5);
        commit(5'd3, 3'd1);
        look1(5'd3,  2'd1, 1'b1, 3'd1);
        look2(5'd12, 2'd1, 1'b0, 3'd0);
        tick();
`ifdef REG_STATUS_BUSY_CNT_EN
        chk("busy_count_post_flush", int'(busy_count), 0);
`endif
        look1(5'd8,  2'd2, 1'b0, 3'd2);
        look2(5'd31, 2'd2, 1'b0, 3'd7);
        tick();
        look1(5'd3,  2'd0, 1'b0, 3'd1);
        look2(5'd12, 2'd0, 1'b0, 3'd0);
        tick();
        tick();

        // rdy_in low freezes everything, including a pending lookup
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(5'd4, 3'd6);
            from_rs_rs1_flag = 1'b1; from_rs_rs1 = 5'd4; from_rs_index = 2'd3;
            tick();
            chk("stall_rs1_flag", int'(to_rs_rs1_flag), 0);
            chk("stall_index",    int'(to_rs_index),    0);
        end
`ifdef REG_STATUS_BUSY_CNT_EN
        chk("busy_count_stall", int'(busy_count), 0);
`endif
        rdy_in = 1'b1;
        issue(5'd4, 3'd6);
        tick();
`ifdef REG_STATUS_BUSY_CNT_EN
        chk("busy_count_resume", int'(busy_count), 1);
`endif
        look1(5'd4, 2'd2, 1'b1, 3'd6);
        look2(5'd7, 2'd2, 1'b0, 3'd5);
        tick();
        tick();
        tick();

        chk("rs1_queue_drained", q1.size(), 0);
        chk("rs2_queue_drained", q2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_status_table.md
Name: reg_status_table

Overview:
- Register status (rename) table alongside the register file.
- Records, per architectural register, whether an in-flight ROB entry will write it, and that entry's tag.
- Answers reservation-station operand lookups one cycle after request, in lockstep with the register file's read return.
- Decoder/issue writes it; the ROB commit and flush buses clear it.

Parameters:
- ROB_WIDTH, 3, log2 of ROB depth; tag width.
- RS_WIDTH, 2, width of the RS slot index echoed with lookup results.

Ports:
- clk_in  input  1  clock; all state updates on posedge.
- rst_in  input  1  asynchronous active-high reset.
- rdy_in  input  1  global enable; when low, all state and outputs hold.
- from_issue_valid  input  1  new instruction with destination issued this cycle.
- from_issue_rd  input  5  destination register.
- from_issue_tag  input  ROB_WIDTH  ROB entry allocated to it.
- from_rs_rs1_flag  input  1  rs1 lookup request.
- from_rs_rs2_flag  input  1  rs2 lookup request.
- from_rs_rs1  input  5  rs1 index.
- from_rs_rs2  input  5  rs2 index.
- from_rs_index  input  RS_WIDTH  requesting RS slot.
- from_rob  input  1  commit writes a register this cycle.
- from_rob_rd  input  5  committed destination.
- from_rob_tag  input  ROB_WIDTH  committing ROB entry.
- from_rob_flush  input  1  misprediction flush.
- to_rs_rs1_flag  output  1  rs1 result valid (one-cycle pulse).
- to_rs_rs2_flag  output  1  rs2 result valid (one-cycle pulse).
- to_rs_index  output  RS_WIDTH  echoed slot.
- to_rs_rs1_busy  output  1  rs1 pending.
- to_rs_rs1_tag  output  ROB_WIDTH  producer tag of rs1.
- to_rs_rs2_busy  output  1  rs2 pending.
- to_rs_rs2_tag  output  ROB_WIDTH  producer tag of rs2.

Behaviour:
- State: busy[31:0] and tag[31:0][ROB_WIDTH-1:0].
- Reset (async, any time, including mid-operation):
  - busy all 0 and tags 0.
  - All to_rs_* outputs 0.
  - Takes effect immediately, regardless of rdy_in.
- rdy_in low: nothing changes; flags keep their value.
- Lookup latency is 1 cycle:
  - from_rs_rsN_flag at edge k gives to_rs_rsN_flag=1 after edge k, plus busy/tag of the requested register.
  - to_rs_index is loaded when either request is active.
  - Flag is 0 in cycles with no request.
- Register 0 always reads busy=0, tag=0.
- Lookup results reflect pre-edge state; same-edge issue or commit is not visible to a same-cycle lookup.
  - Issue with rd == rs1 in the same cycle returns the old producer, giving correct self-dependence semantics.
  - Commit of the looked-up register in the same cycle returns busy=1 with the old tag, matching the register file's stale read. The RS resolves it through the ROB by tag.
- Issue (from_issue_valid, rd != 0): busy[rd] <= 1, tag[rd] <= from_issue_tag. Issue with rd=0 is ignored.
- Commit (from_rob, rd != 0): clear busy[rd] only if tag[rd] == from_rob_tag; otherwise a younger writer owns it and the entry is unchanged.
- Issue and commit to the same rd in the same cycle: issue wins (busy=1, new tag).
- Flush:
  - All busy cleared; tags unchanged.
  - Same-cycle issue and commit are ignored.
  - Same-cycle lookups still return pre-flush state; the RS is flushed anyway.
- No overflow condition exists: tag uniqueness is guaranteed by the ROB.

Optional Feature:
- Macro: REG_STATUS_BUSY_CNT_EN.
- Defined:
  - Adds output busy_count (6 bits) = popcount of busy, registered, updated each enabled edge.
  - Reset 0; flush takes it to 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5 and NUM_REGS=32.
  - The tag typedef sized by ROB_WIDTH.
  - The zero-register constant.
- One natural sub-module: reg_status_read_port.
  - Instantiated twice, for rs1 and rs2.
  - Registered lookup with x0 masking and a valid pulse.
- Table update logic stays in the top module.

Test Plan:
- Reset mid-run with busy[5]=1 -> rst_in high clears immediately; lookup rs1=5 after release returns flag=1, busy=0, tag=0.
- Issue rd=7 tag=3; next cycle lookup rs1=7, index=2 -> following cycle rs1_flag=1, busy=1, tag=3, index=2.
- Issue rd=7 tag=3, then issue rd=7 tag=5, then commit rd=7 tag=3 -> lookup gives busy=1, tag=5; commit rd=7 tag=5 -> busy=0.
- Same cycle: commit rd=9 tag=1 (owner), issue rd=9 tag=4, lookup rs2=9 -> lookup returns busy=1, tag=1; next lookup returns busy=1, tag=4.
- Issue rd=0 tag=2 -> lookup rs1=0 returns busy=0; flush with regs 3, 8 and 31 busy -> all read busy=0; with REG_STATUS_BUSY_CNT_EN, busy_count goes 3 -> 0.
- rdy_in low for 3 cycles during issue rd=4 -> no change; rdy_in high -> update applied once.
